emit_multi: RTL and testbench

//   Parametrised N-channel pour emitter for the dispenser chain. Each channel

---
 rtl/emit_multi.sv | 115 +++++++++++
 tb/tb_emit_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/emit_multi.sv
// N-channel pour emitter: per-channel dose countdown on ticks, then handoff req/ack.
// Optional abort port and behaviour enabled by defining EMIT_ABORT_EN.
module emit_multi #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned CHW = 2
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic           load,
  input  logic [CHW-1:0] ld_chan,
  input  logic [CW-1:0]  ld_count,
  output logic           ld_ack,
  output logic           ld_err,
  input  logic [NCH-1:0] out_ctrl,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] count_req,
  input  logic [NCH-1:0] count_ack,
  output logic [NCH-1:0] busy
`ifdef EMIT_ABORT_EN
  ,
  input  logic [NCH-1:0] abort
`endif
);

  typedef enum logic [1:0] {StIdle, StEmit, StHandoff} state_e;

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic           ld_ack_q, ld_ack_d;
  logic           ld_err_q, ld_err_d;
  logic [NCH-1:0] out_q, out_d;
  logic [NCH-1:0] count_req_q, count_req_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] abort_w;
  logic           ld_ok;

`ifdef EMIT_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = '0;
`endif

  always_comb begin
    ld_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ld_chan == CHW'(i) && state_q[i] == StIdle) ld_ok = 1'b1;
    end
    ld_ack_d = load & ld_ok;
    ld_err_d = load & ~ld_ok;

    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (load && ld_chan == CHW'(i)) begin
            cnt_d[i]   = ld_count;
            state_d[i] = (ld_count != '0) ? StEmit : StHandoff;
          end
        end
        StEmit: begin
          // Abort takes priority over a coincident final tick
          if (abort_w[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = StIdle;
          end else if (out_ctrl[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
            if (cnt_q[i] == CW'(1)) state_d[i] = StHandoff;
          end
        end
        StHandoff: begin
          if (count_ack[i]) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
      out_d[i]       = (state_d[i] == StEmit);
      count_req_d[i] = (state_d[i] == StHandoff);
      busy_d[i]      = (state_d[i] != StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      ld_ack_q    <= 1'b0;
      ld_err_q    <= 1'b0;
      out_q       <= '0;
      count_req_q <= '0;
      busy_q      <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ld_ack_q    <= ld_ack_d;
      ld_err_q    <= ld_err_d;
      out_q       <= out_d;
      count_req_q <= count_req_d;
      busy_q      <= busy_d;
    end
  end

  assign ld_ack    = ld_ack_q;
  assign ld_err    = ld_err_q;
  assign out       = out_q;
  assign count_req = count_req_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_emit_multi.sv
// Directed bench for emit_multi: a 4-channel instance plus a 3-channel one
// for the out-of-range channel case. Define EMIT_ABORT_EN to add abort steps.
module tb_emit_multi;

  logic       clk = 1'b0;
  logic       RESET;
  logic       load;
  logic [1:0] ld_chan;
  logic [7:0] ld_count;
  logic       ld_ack, ld_err;
  logic [3:0] out_ctrl, out, count_req, count_ack, busy, abort;
  logic       s_ld_ack, s_ld_err;
  logic [2:0] s_out, s_count_req, s_busy;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  emit_multi #(.NCH(4), .CW(8), .CHW(2)) u_dut (
    .clk       (clk),
    .RESET     (RESET),
    .load      (load),
    .ld_chan   (ld_chan),
    .ld_count  (ld_count),
    .ld_ack    (ld_ack),
    .ld_err    (ld_err),
    .out_ctrl  (out_ctrl),
    .out       (out),
    .count_req (count_req),
    .count_ack (count_ack),
    .busy      (busy)
`ifdef EMIT_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Three-channel build: ld_chan == 3 is out of range here
  emit_multi #(.NCH(3), .CW(8), .CHW(2)) u_dut3 (
    .clk       (clk),
    .RESET     (RESET),
    .load      (load),
    .ld_chan   (ld_chan),
    .ld_count  (ld_count),
    .ld_ack    (s_ld_ack),
    .ld_err    (s_ld_err),
    .out_ctrl  (3'b000),
    .out       (s_out),
    .count_req (s_count_req),
    .count_ack (3'b000),
    .busy      (s_busy)
`ifdef EMIT_ABORT_EN
    ,
    .abort     (3'b000)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; load = 1'b0; ld_chan = '0; ld_count = '0;
    out_ctrl = '0; count_ack = '0; abort = '0;
    step(); step();
    chk("rst_out", 32'(out), 0);
    chk("rst_req", 32'(count_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack_err", 32'({ld_ack, ld_err}), 0);
    RESET = 1'b0;
    step();

    // Load ch0 with 3, tick on alternate cycles
    load = 1'b1; ld_chan = 2'd0; ld_count = 8'd3;
    step();
    load = 1'b0;
    chk("t1_ld_ack", 32'(ld_ack), 1);
    chk("t1_out0_on", 32'(out), 32'h1);
    chk("t1_busy0", 32'(busy), 32'h1);
    step();
    chk("t1_ack_pulse", 32'(ld_ack), 0);
    out_ctrl = 4'b0001; step(); out_ctrl = '0;
    chk("t1_tick1_out", 32'(out[0]), 1);
    step();
    out_ctrl = 4'b0001; step(); out_ctrl = '0;
    chk("t1_tick2_out", 32'(out[0]), 1);
    chk("t1_tick2_req", 32'(count_req[0]), 0);
    step();
    out_ctrl = 4'b0001; step(); out_ctrl = '0;
    chk("t1_tick3_out", 32'(out[0]), 0);
    chk("t1_tick3_req", 32'(count_req[0]), 1);

    // Hold ack low, then pulse it
    step(); step(); step(); step();
    chk("t2_req_held", 32'(count_req[0]), 1);
    chk("t2_busy_held", 32'(busy[0]), 1);
    count_ack = 4'b0001; step(); count_ack = '0;
    chk("t2_req_drop", 32'(count_req[0]), 0);
    chk("t2_busy_drop", 32'(busy[0]), 0);

    // Zero-count load goes straight to handoff
    load = 1'b1; ld_chan = 2'd1; ld_count = 8'd0;
    step();
    load = 1'b0;
    chk("t3_ld_ack", 32'(ld_ack), 1);
    chk("t3_out1", 32'(out[1]), 0);
    chk("t3_req1", 32'(count_req[1]), 1);

    // Reload of a busy channel is rejected and does not disturb its count
    load = 1'b1; ld_chan = 2'd2; ld_count = 8'd5;
    step();
    chk("t4_first_ack", 32'(ld_ack), 1);
    ld_count = 8'd9;
    step();
    load = 1'b0;
    chk("t4_busy_err", 32'(ld_err), 1);
    chk("t4_busy_noack", 32'(ld_ack), 0);
    for (int k = 0; k < 4; k++) begin
      out_ctrl = 4'b0100; step();
    end
    out_ctrl = '0;
    chk("t4_cnt_kept_out", 32'(out[2]), 1);
    out_ctrl = 4'b0100; step(); out_ctrl = '0;
    chk("t4_cnt_kept_req", 32'(count_req[2]), 1);
    count_ack = 4'b0100; step(); count_ack = '0;
    chk("t4_ch2_idle", 32'(busy[2]), 0);

    // ch3 loads on the 4-ch build, rejected as invalid on the 3-ch build
    load = 1'b1; ld_chan = 2'd3; ld_count = 8'd2;
    step();
    load = 1'b0;
    chk("t4_ch3_ack", 32'(ld_ack), 1);
    chk("t4_inv_err", 32'(s_ld_err), 1);
    chk("t4_inv_noack", 32'(s_ld_ack), 0);
    load = 1'b1; ld_chan = 2'd0; ld_count = 8'd4;
    step();
    load = 1'b0;
    chk("t5_ch0_ack", 32'(ld_ack), 1);
    chk("t5_busy", 32'(busy), 32'hb);

    // Simultaneous ticks on ch0/ch3 with ch1 ack
    out_ctrl = 4'b1001; count_ack = 4'b0010;
    step();
    count_ack = '0;
    chk("t5_out_both", 32'(out), 32'h9);
    chk("t5_req_ch1_drop", 32'(count_req), 0);
    chk("t5_busy_ch1_drop", 32'(busy), 32'h9);
    step();
    out_ctrl = '0;
    chk("t5_out_ch3_done", 32'(out), 32'h1);
    chk("t5_req_ch3", 32'(count_req), 32'h8);

    RESET = 1'b1; out_ctrl = 4'b0001;
    step();
    RESET = 1'b0; out_ctrl = '0;
    chk("t5_rst_out", 32'(out), 0);
    chk("t5_rst_req", 32'(count_req), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    step();
    chk("t5_rst_stays", 32'({out, count_req, busy}), 0);

`ifdef EMIT_ABORT_EN
    // Abort at count 2 with a coincident tick
    load = 1'b1; ld_chan = 2'd0; ld_count = 8'd3;
    step();
    load = 1'b0;
    out_ctrl = 4'b0001; step(); out_ctrl = '0;
    chk("t6_pre_abort_out", 32'(out[0]), 1);
    abort = 4'b0001; out_ctrl = 4'b0001;
    step();
    abort = '0; out_ctrl = '0;
    chk("t6_abort_out", 32'(out[0]), 0);
    chk("t6_abort_busy", 32'(busy[0]), 0);
    chk("t6_abort_req", 32'(count_req[0]), 0);
    step();
    chk("t6_abort_req_later", 32'(count_req[0]), 0);
    // Abort beats the final tick
    load = 1'b1; ld_chan = 2'd0; ld_count = 8'd1;
    step();
    load = 1'b0;
    abort = 4'b0001; out_ctrl = 4'b0001;
    step();
    abort = '0; out_ctrl = '0;
    chk("t6_final_tick_req", 32'(count_req[0]), 0);
    chk("t6_final_tick_busy", 32'(busy[0]), 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
